proto_core: RTL
===============

# proto_core

Parametrised successor to the single-cycle `proto_processor`. It executes the team's 32-bit B/C/WE/WS/ALUop/RA1/RA2/WA/CONST instruction format from an internal, host-loadable instruction memory. It adds start/done run control, halt detection, out-of-range jump trapping, an instruction counter and a generic data width and register count. It sits between the board-level switch/display glue and a host loader, or a testbench acting as one.

## Interface
- `DATA_W`, 32: register/ALU width, ≥ 8.
- `NUM_REGS`, 32: register count, 2..32; reg 0 reads as zero.
- `IMEM_DEPTH`, 64: instruction words, power of two.
- `SW_W`, 10: switch input width, ≤ `DATA_W`.
- `RESULT_REG`, 3: register copied to `result_o` on halt.
- `CNT_W`, 16: instruction counter width.

- `clk_i`  in  1  clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  pulse; starts execution at PC 0 when not running.
- `switches_i`  in  SW_W  external operand, zero-extended.
- `imem_we_i`  in  1  instruction write strobe.
- `imem_addr_i`  in  $clog2(IMEM_DEPTH)  word address.
- `imem_wdata_i`  in  32  instruction word.
- `busy_o`  out  1  high in RUN; imem writes ignored.
- `done_o`  out  1  high in DONE.
- `err_o`  out  1  jump target out of range; valid with `done_o`.
- `result_o`  out  DATA_W  `reg[RESULT_REG]` captured at halt.
- `pc_o`  out  $clog2(IMEM_DEPTH)+2  byte PC.
- `icount_o`  out  CNT_W  instructions retired since start; saturates.

## Operation
- Fields: [31] B, [30] C, [29] WE, [28:27] WS, [26:23] ALUop, [22:18] RA1, [17:13] RA2, [12:8] WA, [7:0] CONST.
- WS: 00 = sign-extended CONST; 01 = `switches_i`, zero-extended; 10 = ALU result; 11 = zero.
- RA/WA index ≥ `NUM_REGS`: reads return 0 and writes are dropped. Writes to reg 0 are dropped.
- ALUop produces result R and flag F:
  - 0000 add; 0001 sub; 0010 xor; 0011 or; 0100 and.
  - 0101 sra; 0110 srl; 0111 sll. Shift amount is the low $clog2(DATA_W) bits of operand 2.
  - 1000 lt; 1001 ltu; 1010 ge; 1011 geu; 1100 eq; 1101 ne. F = comparison; R = zero-extended F.
  - Others: R = 0, F = 0. F = 0 for all non-compare ops.
- Next PC:
  - If B, or C & F: PC + sext(CONST)·4, computed signed at 32 bits.
  - Otherwise: PC + 4.
- Halt: B = 1 with CONST = 0. The instruction's write still happens. The core enters DONE, `result_o` captures `reg[RESULT_REG]` including this cycle's write, and PC holds.
- Trap: a taken target < 0 or ≥ IMEM_DEPTH·4 enters DONE with `err_o` = 1. The write still happens and PC holds at the faulting instruction.
- FSM:
  - IDLE → RUN on `start_i`.
  - RUN → DONE on halt or trap.
  - DONE → RUN on `start_i`.
  - `start_i` in RUN is ignored.
- Start: PC ← 0, `icount_o` ← 0, `err_o` ← 0. Registers are not cleared by start.
- IMEM writes are accepted in IDLE and DONE only and are synchronous. Reads are asynchronous. IMEM contents survive reset.

## Timing
- One instruction per clock in RUN. The start edge only enters RUN; the first instruction executes on the next edge.
- The register write, PC update and `icount_o` increment happen on the same edge. The halting instruction is counted.
- `done_o`, `err_o` and `result_o` are registered and valid the cycle after the halt edge.
- `reset_n` low, including mid-run, immediately clears:
  - state to IDLE;
  - the register file, `pc_o`, `icount_o`, `result_o`;
  - `busy_o`, `done_o`, `err_o`.

## Structure
- `proto_pkg` holds:
  - field bit-position constants;
  - ALUop and WS encodings;
  - the FSM state enum.
- Sub-module `proto_alu`: combinational, parametrised by `DATA_W`, outputs R and F.
- `proto_core` holds the register file, IMEM array, PC/next-PC logic, FSM and counters.

## Test plan
- Reset: hold `reset_n` low → all outputs 0, `busy_o` = 0.
- Shift-add multiply program, 14 words: reg1 = sext(0xFD), reg2 = switches, loop using eq/and/add/sll/sra, halt. With `switches_i` = 10'b1111111011 and `start_i` → `done_o` = 1, `err_o` = 0, `result_o` = 32'hFFFF_F40F (−3 × 1019).
- Same program with `switches_i` = 0 → `result_o` = 0, `icount_o` = 7, `pc_o` = 52.
- Word `B=1, CONST=0x7F` at address 0 → `done_o` = 1, `err_o` = 1, `icount_o` = 1, `pc_o` = 0.
- Pull `reset_n` low for one cycle mid-loop → outputs clear asynchronously. Restart → identical result to the multiply case.
- IMEM write during RUN and a write to reg 0 → both have no effect. Running the program again gives an unchanged result.

Source files
------------

// File: rtl/proto_pkg.sv
// Shared definitions for proto_core: instruction field positions, operand and
// ALU encodings, FSM states and the branch-offset helper.
package proto_pkg;

   localparam int INSTR_W = 32;
   localparam int BIT_B   = 31;
   localparam int BIT_C   = 30;
   localparam int BIT_WE  = 29;
   localparam int WS_HI   = 28;
   localparam int WS_LO   = 27;
   localparam int ALU_HI  = 26;
   localparam int ALU_LO  = 23;
   localparam int RA1_HI  = 22;
   localparam int RA1_LO  = 18;
   localparam int RA2_HI  = 17;
   localparam int RA2_LO  = 13;
   localparam int WA_HI   = 12;
   localparam int WA_LO   = 8;
   localparam int K_HI    = 7;
   localparam int K_LO    = 0;

   typedef enum logic [1:0] {
      WS_CONST = 2'b00,
      WS_SW    = 2'b01,
      WS_ALU   = 2'b10,
      WS_ZERO  = 2'b11
   } ws_e;

   typedef enum logic [3:0] {
      ALU_ADD = 4'h0,
      ALU_SUB = 4'h1,
      ALU_XOR = 4'h2,
      ALU_OR  = 4'h3,
      ALU_AND = 4'h4,
      ALU_SRA = 4'h5,
      ALU_SRL = 4'h6,
      ALU_SLL = 4'h7,
      ALU_LT  = 4'h8,
      ALU_LTU = 4'h9,
      ALU_GE  = 4'hA,
      ALU_GEU = 4'hB,
      ALU_EQ  = 4'hC,
      ALU_NE  = 4'hD
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // Byte offset of a branch: sign-extended word CONST times four.
   function automatic logic [31:0] branch_offset(input logic [7:0] k);
      return {{22{k[7]}}, k, 2'b00};
   endfunction

endpackage

// File: rtl/proto_alu.sv
// Combinational ALU: result R and compare flag F; compares return F as R.
module proto_alu
   import proto_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [3:0]        op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] r_o,
   output logic              f_o
);

   localparam int SH_W = $clog2(DATA_W);

   logic [SH_W-1:0] sh_s;

   assign sh_s = b_i[SH_W-1:0];

   // Operation select; unknown opcodes leave R and F at zero.
   always_comb begin
      r_o = '0;
      f_o = 1'b0;
      case (op_i)
         ALU_ADD: r_o = a_i + b_i;
         ALU_SUB: r_o = a_i - b_i;
         ALU_XOR: r_o = a_i ^ b_i;
         ALU_OR:  r_o = a_i | b_i;
         ALU_AND: r_o = a_i & b_i;
         ALU_SRA: r_o = $unsigned($signed(a_i) >>> sh_s);
         ALU_SRL: r_o = a_i >> sh_s;
         ALU_SLL: r_o = a_i << sh_s;
         ALU_LT:  f_o = ($signed(a_i) < $signed(b_i));
         ALU_LTU: f_o = (a_i < b_i);
         ALU_GE:  f_o = ($signed(a_i) >= $signed(b_i));
         ALU_GEU: f_o = (a_i >= b_i);
         ALU_EQ:  f_o = (a_i == b_i);
         ALU_NE:  f_o = (a_i != b_i);
         default: begin
            r_o = '0;
            f_o = 1'b0;
         end
      endcase
      if (f_o) begin
         r_o = {{(DATA_W-1){1'b0}}, 1'b1};
      end else begin
         r_o = r_o;
      end
   end

endmodule

// File: rtl/proto_core.sv
// Single-cycle core with host-loadable instruction memory, start/done control,
// halt detection and out-of-range jump trapping.
module proto_core
   import proto_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int NUM_REGS   = 32,
   parameter int IMEM_DEPTH = 64,
   parameter int SW_W       = 10,
   parameter int RESULT_REG = 3,
   parameter int CNT_W      = 16
) (
   input  logic                            clk_i,
   input  logic                            reset_n,
   input  logic                            start_i,
   input  logic [SW_W-1:0]                 switches_i,
   input  logic                            imem_we_i,
   input  logic [$clog2(IMEM_DEPTH)-1:0]   imem_addr_i,
   input  logic [31:0]                     imem_wdata_i,
   output logic                            busy_o,
   output logic                            done_o,
   output logic                            err_o,
   output logic [DATA_W-1:0]               result_o,
   output logic [$clog2(IMEM_DEPTH)+1:0]   pc_o,
   output logic [CNT_W-1:0]                icount_o
);

   localparam int AW   = $clog2(IMEM_DEPTH);
   localparam int PC_W = AW + 2;

   logic [INSTR_W-1:0] imem_q [IMEM_DEPTH];
   logic [DATA_W-1:0]  rf_q [NUM_REGS];

   state_e             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [CNT_W-1:0]   icount_q, icount_d;
   logic               err_q, err_d;
   logic [DATA_W-1:0]  result_q, result_d;

   logic [INSTR_W-1:0] instr_s;
   logic               b_s, c_s, we_s;
   ws_e                ws_s;
   logic [3:0]         op_s;
   logic [4:0]         ra1_s, ra2_s, wa_s;
   logic [7:0]         k_s;
   logic [DATA_W-1:0]  rd1_s, rd2_s, alu_r_s, wdata_s;
   logic               alu_f_s;
   logic               run_s, wr_en_s, taken_s, halt_s, trap_s;
   logic [31:0]        target_s;

   assign instr_s = imem_q[pc_q[PC_W-1:2]];
   assign b_s     = instr_s[BIT_B];
   assign c_s     = instr_s[BIT_C];
   assign we_s    = instr_s[BIT_WE];
   assign ws_s    = ws_e'(instr_s[WS_HI:WS_LO]);
   assign op_s    = instr_s[ALU_HI:ALU_LO];
   assign ra1_s   = instr_s[RA1_HI:RA1_LO];
   assign ra2_s   = instr_s[RA2_HI:RA2_LO];
   assign wa_s    = instr_s[WA_HI:WA_LO];
   assign k_s     = instr_s[K_HI:K_LO];

   // Reg 0 and indices beyond the file read as zero.
   assign rd1_s = (ra1_s != 5'd0 && int'(ra1_s) < NUM_REGS) ? rf_q[ra1_s] : '0;
   assign rd2_s = (ra2_s != 5'd0 && int'(ra2_s) < NUM_REGS) ? rf_q[ra2_s] : '0;

   proto_alu #(.DATA_W(DATA_W)) u_alu (
      .op_i (op_s),
      .a_i  (rd1_s),
      .b_i  (rd2_s),
      .r_o  (alu_r_s),
      .f_o  (alu_f_s)
   );

   // Write-back operand select.
   always_comb begin
      wdata_s = '0;
      case (ws_s)
         WS_CONST: wdata_s = DATA_W'($signed(k_s));
         WS_SW:    wdata_s = DATA_W'(switches_i);
         WS_ALU:   wdata_s = alu_r_s;
         WS_ZERO:  wdata_s = '0;
         default:  wdata_s = '0;
      endcase
   end

   assign run_s    = (state_q == ST_RUN);
   assign wr_en_s  = run_s && we_s && (wa_s != 5'd0) && (int'(wa_s) < NUM_REGS);
   assign taken_s  = b_s | (c_s & alu_f_s);
   assign target_s = 32'(pc_q) + branch_offset(k_s);
   assign halt_s   = b_s && (k_s == 8'h00);
   assign trap_s   = taken_s && (target_s[31] || (target_s >= 32'(IMEM_DEPTH * 4)));

   // Run-control FSM with PC, counter, error and result next-state.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      icount_d = icount_q;
      err_d    = err_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               state_d  = ST_RUN;
               pc_d     = '0;
               icount_d = '0;
               err_d    = 1'b0;
            end else begin
               state_d  = state_q;
            end
         end
         ST_RUN: begin
            if (icount_q == {CNT_W{1'b1}}) begin
               icount_d = icount_q;
            end else begin
               icount_d = icount_q + CNT_W'(1);
            end
            if (trap_s) begin
               state_d = ST_DONE;
               err_d   = 1'b1;
            end else if (halt_s) begin
               state_d  = ST_DONE;
               result_d = (wr_en_s && (wa_s == 5'(RESULT_REG))) ? wdata_s : rf_q[RESULT_REG];
            end else if (taken_s) begin
               pc_d = target_s[PC_W-1:0];
            end else begin
               pc_d = pc_q + PC_W'(4);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and status registers.
   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         pc_q     <= '0;
         icount_q <= '0;
         err_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         icount_q <= icount_d;
         err_q    <= err_d;
         result_q <= result_d;
      end
   end

   // Register file; cleared by reset, never by start.
   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            rf_q[i] <= '0;
         end
      end else if (wr_en_s) begin
         rf_q[wa_s] <= wdata_s;
      end
   end

   // Instruction memory has no reset so a loaded program survives reset_n.
   always_ff @(posedge clk_i) begin
      if (imem_we_i && !run_s) begin
         imem_q[imem_addr_i] <= imem_wdata_i;
      end
   end

   assign busy_o   = run_s;
   assign done_o   = (state_q == ST_DONE);
   assign err_o    = err_q;
   assign result_o = result_q;
   assign pc_o     = pc_q;
   assign icount_o = icount_q;

endmodule
